rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
Round-robin arbiter that shares one 2-to-4 decoded resource select among four requesters. It grants exactly one requester at a time and holds the grant until that requester releases it. It drives the decoder-style one-hot select lines plus the encoded index. It sits between the requesting blocks and the shared resource, which is addressed by a 2-bit select with enable.

Parameters:
- MAX_HOLD, 15: maximum grant length in cycles. Used only when ARB_TIMEOUT_EN is defined.
- CNT_W, 4: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- req  input  4  request vector; req[i] high means requester i wants the resource.
- done  input  1  current grantee releases the resource this cycle.
- gnt  output  4  one-hot grant; all zero when no grant.
- gnt_idx  output  2  encoded index of the current grantee; holds the last value when idle.
- gnt_vld  output  1  a grant is active (drives the decoder enable).
- timeout  output  1  one-cycle pulse on forced release. Present only with ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE, gnt=4'b0000, gnt_idx=2'd0, gnt_vld=0, timeout=0.
  - last pointer=2'd3, so requester 0 has first priority after reset.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If |req, select the first requester with req high, searching from last+1 upward with modulo-4 wrap (3 wraps to 0).
  - On the next edge: gnt_idx=selected index, gnt=one-hot decode of that index, gnt_vld=1, last=selected index, state=GRANT.
  - Latency from req rising in IDLE to gnt high is 1 cycle.
  - If req=0, stay in IDLE with all outputs low.
- GRANT:
  - gnt and gnt_idx are held stable.
  - Release condition: done=1, or req[gnt_idx]=0 (requester withdrew).
  - On release, the next edge gives gnt=0, gnt_vld=0, state=IDLE.
  - Release is followed by one mandatory idle cycle before the next grant. This is the decoder settling gap.
- Changes on req for non-granted requesters are ignored during GRANT.
- Simultaneous done and a new req in the same cycle: release first, then arbitrate in IDLE on the following cycle.
- Fairness: a requester that holds req high continuously is granted within at most 3 intervening grants.
- gnt always equals the decode of gnt_idx gated by gnt_vld. It is never multi-hot.
- Reset asserted mid-grant: the grant is dropped on that edge and the pointer returns to 3. There is no partial-state carry-over.
- The hold counter counts cycles in GRANT. It clears on entering GRANT and saturates at 2^CNT_W-1.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - When the hold counter reaches MAX_HOLD with no release, force a release on the next edge, identical to done.
  - timeout pulses high for exactly that one cycle, aligned with gnt_vld falling.
  - The pointer still advances, so the timed-out requester goes to lowest priority.
- Undefined:
  - No timeout port and no forced release.
  - The counter is removed; the grant is held indefinitely until done or req withdrawal.

Decomposition:
- Shared package arb_pkg:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NREQ=4, IDX_W=2.
- Sub-module dec2to4 (enable, 2-bit index in, 4-bit one-hot out): instantiated once to form gnt from gnt_idx and gnt_vld.
- Rotating priority search stays inline as combinational logic.

Test Plan:
- Reset then req=4'b1111 with done each grant → gnt order 0001, 0010, 0100, 1000, 0001. Each grant is separated by one idle cycle.
- req=4'b0100 only → gnt=0100, gnt_idx=2 one cycle later. Dropping req[2] → gnt=0000 on the next edge.
- Grant held at idx 3 with req=4'b1001 and done pulsed → next grant is idx 0 (wrap), not idx 3.
- During a grant to idx 1, toggle req[0] and req[3] → gnt stays 0010 throughout. After done, idx 3 is granted (search from 2 upward).
- Assert rst_n=0 for one cycle mid-grant → next edge gives gnt=0, gnt_vld=0. Then req=4'b1000 → gnt_idx=3.
- With ARB_TIMEOUT_EN and MAX_HOLD=15, hold req[1] high with no done → gnt_vld falls and timeout=1 for one cycle, 16 cycles after the grant. The next grant to another requester follows the idle gap.

Source files
------------

// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared constants for the four-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/dec2to4.sv
// ============================================================================
// Module      : dec2to4
// Description : 2-to-4 one-hot decoder with enable; all outputs low when
//               disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec2to4
    import arb_pkg::*;
(
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_idx,
    output logic [NREQ-1:0]  o_dec
);

    always_comb begin
        o_dec = '0;
        if (i_en) begin
            o_dec[i_idx] = 1'b1;
        end
    end

endmodule : dec2to4

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
// Module      : rr_arbiter4
// Description : Four-requester round-robin arbiter with grant hold until
//               release. Optional forced release after MAX_HOLD cycles is
//               enabled by defining ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_last;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [IDX_W-1:0] w_cand;
    logic             w_force;
    logic             w_release;

    // Rotating search: first requester above the last grantee, wrapping at 4.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_cand  = r_last;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = r_last + k[IDX_W-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_cnt_sat  = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    assign w_force = (r_state == ST_GRANT) && (r_cnt == c_max_hold)
                     && !done && req[r_idx];

    // Counter sits at zero in IDLE so it starts from zero on each new grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt != c_cnt_sat) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
`endif

    assign w_release = done || !req[r_idx] || w_force;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_last  <= 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_GRANT;
                        r_idx   <= w_pick;
                        r_last  <= w_pick;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt_vld = (r_state == ST_GRANT);
    assign gnt_idx = r_idx;

    dec2to4 u_dec (
        .i_en  (gnt_vld),
        .i_idx (r_idx),
        .o_dec (gnt)
    );

endmodule : rr_arbiter4

`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
// ============================================================================
// Module      : tb_rr_arbiter4
// Description : Directed self-checking bench for rr_arbiter4; the timeout
//               steps run only when ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
`ifdef ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int n_vec;
    int n_err;

    rr_arbiter4 #(
        .MAX_HOLD (15),
        .CNT_W    (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_gnt,
                       input logic [1:0] e_idx, input logic e_vld);
        n_vec++;
        assert ({gnt, gnt_idx, gnt_vld} === {e_gnt, e_idx, e_vld})
        else begin
            n_err++;
            $error("FAIL %s observed gnt=%b idx=%0d vld=%b expected gnt=%b idx=%0d vld=%b",
                   tag, gnt, gnt_idx, gnt_vld, e_gnt, e_idx, e_vld);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic chk_to(input string tag, input logic e_to);
        n_vec++;
        assert (timeout === e_to)
        else begin
            n_err++;
            $error("FAIL %s observed timeout=%b expected timeout=%b", tag, timeout, e_to);
        end
    endtask
`endif

    initial begin
        logic [1:0] exp_seq [5];
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset state
        tick();
        tick();
        chk("reset", 4'b0000, 2'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
        chk_to("reset_to", 1'b0);
`endif
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", 4'b0000, 2'd0, 1'b0);

        // All requesting, done on each grant: 0,1,2,3,0 with idle gaps
        req = 4'b1111;
        tick();
        chk("rr_grant0", 4'b0001, 2'd0, 1'b1);
        for (int i = 1; i < 5; i++) begin
            done = 1'b1;
            tick();
            chk("rr_gap", 4'b0000, exp_seq[i-1], 1'b0);
            done = 1'b0;
            tick();
            chk("rr_grant", 4'b0001 << exp_seq[i], exp_seq[i], 1'b1);
        end
        done = 1'b1;
        tick();
        chk("rr_last_rel", 4'b0000, 2'd0, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        tick();
        chk("rr_idle", 4'b0000, 2'd0, 1'b0);

        // Single requester 2, then withdrawal
        req = 4'b0100;
        tick();
        chk("single2_grant", 4'b0100, 2'd2, 1'b1);
        tick();
        chk("single2_hold", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000;
        tick();
        chk("single2_withdraw", 4'b0000, 2'd2, 1'b0);
        tick();
        chk("single2_idle", 4'b0000, 2'd2, 1'b0);

        // Wrap: last=2, req=1001 -> 3, then done -> 0
        req = 4'b1001;
        tick();
        chk("wrap_grant3", 4'b1000, 2'd3, 1'b1);
        done = 1'b1;
        tick();
        chk("wrap_gap", 4'b0000, 2'd3, 1'b0);
        done = 1'b0;
        tick();
        chk("wrap_grant0", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        chk("wrap_release", 4'b0000, 2'd0, 1'b0);

        // Grant to 1, other requests toggle and are ignored
        req = 4'b0010;
        tick();
        chk("ign_grant1", 4'b0010, 2'd1, 1'b1);
        req = 4'b0011;
        tick();
        chk("ign_hold_a", 4'b0010, 2'd1, 1'b1);
        req = 4'b1010;
        tick();
        chk("ign_hold_b", 4'b0010, 2'd1, 1'b1);
        req = 4'b1011;
        tick();
        chk("ign_hold_c", 4'b0010, 2'd1, 1'b1);
        done = 1'b1;
        tick();
        chk("ign_release", 4'b0000, 2'd1, 1'b0);
        done = 1'b0;
        tick();
        chk("ign_next3", 4'b1000, 2'd3, 1'b1);

        // Reset mid-grant
        rst_n = 1'b0;
        tick();
        chk("midrst_drop", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1000;
        tick();
        chk("midrst_grant3", 4'b1000, 2'd3, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("midrst2_drop", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        chk("midrst_ptr3", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        chk("midrst_release", 4'b0000, 2'd0, 1'b0);

        // Long hold on requester 1
        req = 4'b0010;
        tick();
        chk("hold_grant1", 4'b0010, 2'd1, 1'b1);
        req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            tick();
            chk("to_hold", 4'b0010, 2'd1, 1'b1);
            chk_to("to_quiet", 1'b0);
        end
        tick();
        chk("to_release", 4'b0000, 2'd1, 1'b0);
        chk_to("to_pulse", 1'b1);
        tick();
        chk("to_next0", 4'b0001, 2'd0, 1'b1);
        chk_to("to_pulse_end", 1'b0);
`else
        for (int c = 1; c < 24; c++) begin
            tick();
            chk("hold_forever", 4'b0010, 2'd1, 1'b1);
        end
        done = 1'b1;
        tick();
        chk("hold_done", 4'b0000, 2'd1, 1'b0);
        done = 1'b0;
        tick();
        chk("hold_next0", 4'b0001, 2'd0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_arbiter4

`default_nettype wire
